gcd_issue_unit: RTL and testbench

Front-end sequencer that sits directly upstream of the `gcd` core. It accepts operand pairs over a valid/ready stream and buffers them in a small FIFO. For each pair it either launches the core with a one-cycle `go` and holds the operands stable until `core_done`, or bypasses the core when an operand is zero, since subtractive GCD never terminates on zero. It returns each result over a valid/ready stream, and a watchdog converts a hung core into an error result.

---
 rtl/gcd_issue_unit.sv | 145 ++++++++++++++
 tb/tb_gcd_issue_unit.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_issue_unit.sv
`default_nettype none
// ============================================================================
// gcd_issue_unit : operand FIFO + launch/bypass/watchdog sequencer for a gcd core
// Revision 1.0
// ============================================================================
module gcd_issue_unit #(
  parameter int W       = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1048575
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_x,
  input  logic [W-1:0] i_in_y,
  output logic         o_go,
  output logic [W-1:0] o_core_x,
  output logic [W-1:0] o_core_y,
  input  logic         i_core_done,
  input  logic [W-1:0] i_core_gcd,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic [W-1:0] o_res_gcd,
  output logic         o_res_err,
  output logic         o_busy
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam int c_tw = $clog2(TIMEOUT + 1);
  localparam logic [c_cw-1:0] c_depth_full = c_cw'(DEPTH);
  localparam logic [c_tw-1:0] c_wdog_last  = c_tw'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t            r_state;
  logic [W-1:0]      r_mem_x [DEPTH];
  logic [W-1:0]      r_mem_y [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_cw-1:0]   r_count;
  logic [c_tw-1:0]   r_wdog;
  logic              w_push;
  logic              w_pop;
  logic              w_zero_op;
  logic [W-1:0]      w_head_x;
  logic [W-1:0]      w_head_y;

  assign o_in_ready = (r_count != c_depth_full);
  assign w_push     = i_in_valid && o_in_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_head_x   = r_mem_x[r_rd_ptr];
  assign w_head_y   = r_mem_y[r_rd_ptr];
  // Subtractive GCD never terminates on a zero operand, so such pairs skip the core.
  assign w_zero_op  = (w_head_x == '0) || (w_head_y == '0);
  assign o_busy     = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_x[r_wr_ptr] <= i_in_x;
      r_mem_y[r_wr_ptr] <= i_in_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cw'(1);
        2'b01:   r_count <= r_count - c_cw'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wdog      <= '0;
      o_go        <= 1'b0;
      o_core_x    <= '0;
      o_core_y    <= '0;
      o_res_valid <= 1'b0;
      o_res_gcd   <= '0;
      o_res_err   <= 1'b0;
    end else begin
      o_go <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            if (w_zero_op) begin
              o_res_gcd   <= w_head_x | w_head_y;
              o_res_err   <= 1'b0;
              o_res_valid <= 1'b1;
              r_state     <= S_RESULT;
            end else begin
              o_core_x <= w_head_x;
              o_core_y <= w_head_y;
              o_go     <= 1'b1;
              r_state  <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wdog <= r_wdog + c_tw'(1);
          // A done arriving on the final watchdog cycle still wins.
          if (i_core_done) begin
            o_res_gcd   <= i_core_gcd;
            o_res_err   <= 1'b0;
            o_res_valid <= 1'b1;
            r_state     <= S_RESULT;
          end else if (r_wdog == c_wdog_last) begin
            o_res_gcd   <= '0;
            o_res_err   <= 1'b1;
            o_res_valid <= 1'b1;
            r_state     <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gcd_issue_unit.sv
`default_nettype none
// ============================================================================
// tb_gcd_issue_unit : self-checking bench with a stub gcd core and Euclid reference
// Revision 1.0
// ============================================================================
module tb_gcd_issue_unit;
  localparam int W       = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic         go;
  logic [W-1:0] core_x;
  logic [W-1:0] core_y;
  logic         core_done;
  logic [W-1:0] core_gcd;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_gcd;
  logic         res_err;
  logic         busy;

  int           vectors = 0;
  int           miscompares = 0;
  int           stub_lat = 10;
  int           stub_cnt;
  logic         stub_busy;
  logic [W-1:0] stub_res;
  logic [W-1:0] exp_q[$];

  gcd_issue_unit #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_x     (in_x),
    .i_in_y     (in_y),
    .o_go       (go),
    .o_core_x   (core_x),
    .o_core_y   (core_y),
    .i_core_done(core_done),
    .i_core_gcd (core_gcd),
    .o_res_valid(res_valid),
    .i_res_ready(res_ready),
    .o_res_gcd  (res_gcd),
    .o_res_err  (res_err),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
    logic [W-1:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Stub core: done pulses stub_lat cycles after the go cycle, sharing rst_n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done <= 1'b0;
      core_gcd  <= '0;
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_res  <= '0;
    end else begin
      core_done <= 1'b0;
      if (go) begin
        stub_busy <= 1'b1;
        stub_cnt  <= stub_lat - 1;
        stub_res  <= gcd_ref(core_x, core_y);
      end else if (stub_busy) begin
        if (stub_cnt <= 1) begin
          core_done <= 1'b1;
          core_gcd  <= stub_res;
          stub_busy <= 1'b0;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    tick();
    in_valid = 1'b0;
    in_x = $urandom;
    in_y = $urandom;
  endtask

  task automatic wait_valid(input int max_cyc, output int cyc, output int gos);
    cyc = -1;
    gos = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      tick();
      if (go) gos++;
      if (res_valid) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({in_ready, go, res_valid, res_err, busy} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, expected 10000", {in_ready, go, res_valid, res_err, busy});
    end
    vectors++;
    if (core_x !== '0 || core_y !== '0) begin
      miscompares++;
      $display("FAIL reset_core_ops: got x=%0d y=%0d, expected 0 0", core_x, core_y);
    end
    vectors++;
    if (res_gcd !== '0) begin
      miscompares++;
      $display("FAIL reset_res_gcd: got %0d, expected 0", res_gcd);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_core_path();
    int gos, done_at, valid_at;
    bit unstable;
    stub_lat = 10;
    res_ready = 1'b0;
    push(48, 18);
    vectors++;
    if (go !== 1'b0) begin
      miscompares++;
      $display("FAIL core_early_go: got %b, expected 0", go);
    end
    tick();
    vectors++;
    if (go !== 1'b1 || core_x !== 48 || core_y !== 18) begin
      miscompares++;
      $display("FAIL core_launch: got go=%b x=%0d y=%0d, expected 1 48 18", go, core_x, core_y);
    end
    gos = 1; done_at = -1; valid_at = -1; unstable = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (go) gos++;
      if (core_x !== 48 || core_y !== 18) unstable = 1'b1;
      if (core_done) done_at = c;
      if (res_valid) begin
        valid_at = c;
        break;
      end
    end
    vectors++;
    if (gos != 1 || unstable) begin
      miscompares++;
      $display("FAIL core_go_hold: got gos=%0d unstable=%0d, expected 1 0", gos, unstable);
    end
    vectors++;
    if (valid_at != 11 || done_at != 10) begin
      miscompares++;
      $display("FAIL core_latency: got done@%0d valid@%0d, expected 10 11", done_at, valid_at);
    end
    vectors++;
    if (res_gcd !== 6 || res_err !== 1'b0) begin
      miscompares++;
      $display("FAIL core_result: got gcd=%0d err=%b, expected 6 0", res_gcd, res_err);
    end
    repeat (3) tick();
    vectors++;
    if (res_valid !== 1'b1 || res_gcd !== 6 || res_err !== 1'b0) begin
      miscompares++;
      $display("FAIL core_hold: got v=%b gcd=%0d err=%b, expected 1 6 0", res_valid, res_gcd, res_err);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || core_x !== 48) begin
      miscompares++;
      $display("FAIL core_release: got v=%b busy=%b x=%0d, expected 0 0 48", res_valid, busy, core_x);
    end
  endtask

  task automatic test_bypass();
    bit saw_go;
    saw_go = 1'b0;
    in_valid = 1'b1; in_x = 0; in_y = 35;
    tick();
    saw_go |= go;
    in_x = 0; in_y = 0;
    tick();
    in_valid = 1'b0;
    saw_go |= go;
    vectors++;
    if (res_valid !== 1'b1 || res_gcd !== 35 || res_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_first: got v=%b gcd=%0d err=%b, expected 1 35 0", res_valid, res_gcd, res_err);
    end
    res_ready = 1'b1;
    tick();
    saw_go |= go;
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_gap: got v=%b, expected 0", res_valid);
    end
    tick();
    saw_go |= go;
    vectors++;
    if (res_valid !== 1'b1 || res_gcd !== 0 || res_err !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_second: got v=%b gcd=%0d err=%b, expected 1 0 0", res_valid, res_gcd, res_err);
    end
    tick();
    res_ready = 1'b0;
    saw_go |= go;
    vectors++;
    if (saw_go !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bypass_no_go: got go_seen=%b busy=%b, expected 0 0", saw_go, busy);
    end
  endtask

  task automatic test_fill_order();
    logic [W-1:0] x, y, e;
    int got;
    exp_q.delete();
    res_ready = 1'b0;
    stub_lat = 3;
    for (int i = 0; i < 5; i++) begin
      x = W'($urandom_range(1, 1000));
      y = W'($urandom_range(1, 1000));
      exp_q.push_back(gcd_ref(x, y));
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_ready_%0d: got %b, expected 1", i, in_ready);
      end
      push(x, y);
    end
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: got in_ready=%b, expected 0", in_ready);
    end
    repeat (20) tick();
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_stall: got rdy=%b busy=%b v=%b, expected 0 1 1", in_ready, busy, res_valid);
    end
    res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 400 && got < 5; c++) begin
      if (res_valid) begin
        e = exp_q.pop_front();
        vectors++;
        if (res_gcd !== e || res_err !== 1'b0) begin
          miscompares++;
          $display("FAIL fill_order_%0d: got gcd=%0d err=%b, expected %0d 0", got, res_gcd, res_err, e);
        end
        got++;
      end
      tick();
    end
    res_ready = 1'b0;
    vectors++;
    if (got != 5) begin
      miscompares++;
      $display("FAIL fill_count: got %0d results, expected 5", got);
    end
  endtask

  task automatic test_watchdog(input int lat, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic exp_err, input logic [W-1:0] exp_gcd);
    int cyc, gos;
    stub_lat = lat;
    res_ready = 1'b0;
    push(x, y);
    tick();
    vectors++;
    if (go !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_go_lat%0d: got %b, expected 1", lat, go);
    end
    wait_valid(40, cyc, gos);
    vectors++;
    if (cyc != TIMEOUT + 1 || res_err !== exp_err || res_gcd !== exp_gcd) begin
      miscompares++;
      $display("FAIL wd_result_lat%0d: got cyc=%0d err=%b gcd=%0d, expected %0d %b %0d",
               lat, cyc, res_err, res_gcd, TIMEOUT + 1, exp_err, exp_gcd);
    end
    repeat (3) tick();
    vectors++;
    if (res_valid !== 1'b1 || res_err !== exp_err || res_gcd !== exp_gcd) begin
      miscompares++;
      $display("FAIL wd_hold_lat%0d: got v=%b err=%b gcd=%0d, expected 1 %b %0d",
               lat, res_valid, res_err, res_gcd, exp_err, exp_gcd);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int pending;
    bit xfer;
    logic [W-1:0] x, y, e;
    pending = 40;
    exp_q.delete();
    for (int c = 0; c < 8000 && (pending > 0 || exp_q.size() > 0); c++) begin
      x = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 5000));
      y = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 5000));
      in_x = x;
      in_y = y;
      in_valid = (pending > 0) && ($urandom_range(0, 2) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      stub_lat = $urandom_range(2, TIMEOUT);
      if (in_valid && in_ready) begin
        exp_q.push_back(gcd_ref(x, y));
        pending--;
      end
      xfer = res_valid && res_ready;
      if (xfer) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rand_unexpected: got gcd=%0d, expected no result", res_gcd);
        end else begin
          e = exp_q.pop_front();
          if (res_gcd !== e || res_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_result: got gcd=%0d err=%b, expected %0d 0", res_gcd, res_err, e);
          end
        end
      end
      tick();
      if (xfer) begin
        vectors++;
        if (res_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_gap: got v=%b after transfer, expected 0", res_valid);
        end
      end
    end
    in_valid = 1'b0;
    res_ready = 1'b0;
    vectors++;
    if (pending != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_drain: got pending=%0d outstanding=%0d, expected 0 0", pending, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int cyc, gos;
    bit stray;
    stub_lat = 15;
    res_ready = 1'b0;
    push(9, 6);
    push(10, 4);
    push(15, 5);
    tick();
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_pre: got busy=%b rdy=%b v=%b, expected 1 1 0", busy, in_ready, res_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, go, res_valid, res_err, busy} !== 5'b10000 ||
        core_x !== '0 || core_y !== '0 || res_gcd !== '0) begin
      miscompares++;
      $display("FAIL rmid_async: got flags=%b x=%0d y=%0d gcd=%0d, expected 10000 0 0 0",
               {in_ready, go, res_valid, res_err, busy}, core_x, core_y, res_gcd);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    stub_lat = 5;
    push(12, 8);
    wait_valid(60, cyc, gos);
    vectors++;
    if (cyc < 0 || gos != 1 || res_gcd !== 4 || res_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_after: got cyc=%0d gos=%0d gcd=%0d err=%b, expected >0 1 4 0",
               cyc, gos, res_gcd, res_err);
    end
    res_ready = 1'b1;
    tick();
    stray = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (res_valid || go || busy) stray = 1'b1;
    end
    res_ready = 1'b0;
    vectors++;
    if (stray !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_discard: got stray activity=%b, expected 0", stray);
    end
  endtask

  initial begin
    test_reset();
    test_core_path();
    test_bypass();
    test_fill_order();
    test_watchdog(TIMEOUT + 2, 7, 3, 1'b1, 0);
    test_watchdog(TIMEOUT, 21, 14, 1'b0, 7);
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no completion, expected finish within 1ms");
    $fatal(1, "bench stalled");
  end

endmodule
`default_nettype wire
